key_debounce_filter: RTL and testbench

//  Conditions one raw active-low pushbutton (board KEY) before it reaches the
//  HPS system's key PIO input (key_external_connection_export).

---
 rtl/key_debounce_filter.sv | 207 ++++++++++++++++++++
 tb/tb_key_debounce_filter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_filter.sv
// -----------------------------------------------------------------------------
// key_debounce_filter
//
// Conditions one raw active-low pushbutton before it reaches the HPS key PIO.
// The raw input is brought into the clock domain with a two-flop synchroniser.
// A four-state FSM then accepts a level change only after the input has been
// stable long enough. From the accepted level it derives one-cycle strobes, a
// long-press flag and a saturating press counter.
//
// reset_reset_n is expected to come from the system reset controller, which
// asserts it asynchronously and releases it synchronously to clk_clk. No
// further reset synchroniser is placed here, so the first rising edge after
// release is the first edge that samples key_n_raw.
//
// Ports
//   clk_clk        in   1      system clock (shared with the HPS system)
//   reset_reset_n  in   1      asynchronous active-low reset
//   key_n_raw      in   1      raw pushbutton, 0 = pressed, asynchronous
//   clr_count      in   1      synchronous clear of press_count
//   key_level      out  1      debounced level, 1 = pressed
//   press_pulse    out  1      one-cycle strobe on accepted press
//   release_pulse  out  1      one-cycle strobe on accepted release
//   long_press     out  1      1 while accepted press lasted >= LONG_CYCLES
//   press_count    out  CNT_W  accepted presses, saturating at all-ones
//
// State           | meaning
// ----------------+-----------------------------------------------------------
// ST_IDLE         | key accepted as released, waiting for a pressed sample
// ST_PRESS_WAIT   | pressed seen, counting stable cycles before accepting
// ST_PRESSED      | key accepted as pressed, hold time running
// ST_RELEASE_WAIT | released seen, counting stable cycles before accepting
// -----------------------------------------------------------------------------
module key_debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_W           = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             key_n_raw,
  input  logic             clr_count,
  output logic             key_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_press,
  output logic [CNT_W-1:0] press_count
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // registers
  logic              r_sync1;
  logic              r_sync2;
  state_t            r_state;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_key_level;
  logic              r_press_pulse;
  logic              r_release_pulse;
  logic              r_long_press;
  logic [CNT_W-1:0]  r_press_count;

  // next-state / combinational
  logic              w_pressed;
  logic              w_press_acc;
  state_t            w_state_nxt;
  logic [DEB_W-1:0]  w_deb_cnt_nxt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic              w_key_level_nxt;
  logic              w_press_pulse_nxt;
  logic              w_release_pulse_nxt;
  logic              w_long_press_nxt;
  logic [CNT_W-1:0]  w_press_count_nxt;

  // Synchroniser resets to the released level so a key held through reset
  // shows up as a fresh press once reset is removed.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_n_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state         <= ST_IDLE;
      r_deb_cnt       <= '0;
      r_hold_cnt      <= '0;
      r_key_level     <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_press    <= 1'b0;
      r_press_count   <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_deb_cnt       <= w_deb_cnt_nxt;
      r_hold_cnt      <= w_hold_cnt_nxt;
      r_key_level     <= w_key_level_nxt;
      r_press_pulse   <= w_press_pulse_nxt;
      r_release_pulse <= w_release_pulse_nxt;
      r_long_press    <= w_long_press_nxt;
      r_press_count   <= w_press_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_deb_cnt_nxt       = r_deb_cnt;
    w_hold_cnt_nxt      = r_hold_cnt;
    w_key_level_nxt     = r_key_level;
    w_press_pulse_nxt   = 1'b0;
    w_release_pulse_nxt = 1'b0;
    w_long_press_nxt    = r_long_press;
    w_press_acc         = 1'b0;

    // Hold time keeps running through a release glitch so long_press timing
    // is measured from the accepted press, not from the last glitch.
    if ((r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT)) begin
      if (r_hold_cnt == HOLD_LAST) begin
        w_long_press_nxt = 1'b1;
      end else begin
        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (w_pressed) begin
          w_state_nxt   = ST_PRESS_WAIT;
          w_deb_cnt_nxt = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!w_pressed) begin
          w_state_nxt = ST_IDLE;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt       = ST_PRESSED;
          w_key_level_nxt   = 1'b1;
          w_press_pulse_nxt = 1'b1;
          w_press_acc       = 1'b1;
          w_hold_cnt_nxt    = '0;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
        end
      end

      ST_PRESSED: begin
        if (!w_pressed) begin
          w_state_nxt   = ST_RELEASE_WAIT;
          w_deb_cnt_nxt = '0;
        end
      end

      ST_RELEASE_WAIT: begin
        if (w_pressed) begin
          w_state_nxt = ST_PRESSED;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt         = ST_IDLE;
          w_key_level_nxt     = 1'b0;
          w_release_pulse_nxt = 1'b1;
          w_long_press_nxt    = 1'b0;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Clear takes priority, then the coincident press is counted on top of it.
  always_comb begin
    w_press_count_nxt = r_press_count;
    if (clr_count) begin
      w_press_count_nxt = w_press_acc ? CNT_W'(1) : '0;
    end else if (w_press_acc && (r_press_count != CNT_MAX)) begin
      w_press_count_nxt = r_press_count + CNT_W'(1);
    end
  end

  assign key_level     = r_key_level;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign long_press    = r_long_press;
  assign press_count   = r_press_count;

endmodule

// File: tb/tb_key_debounce_filter.sv
// Testbench for key_debounce_filter with short debounce/long-press times.
// The reference model accepts a level change once the last D+1 synchronised
// samples all disagree with the accepted level, and derives long_press from
// the elapsed cycles since the accepted press.
module tb_key_debounce_filter;

  localparam int D  = 4;
  localparam int LG = 16;
  localparam int CW = 4;

  logic          clk_clk;
  logic          reset_reset_n;
  logic          key_n_raw;
  logic          clr_count;
  logic          key_level;
  logic          press_pulse;
  logic          release_pulse;
  logic          long_press;
  logic [CW-1:0] press_count;

  int n_checks;
  int n_errors;

  key_debounce_filter #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (LG),
    .CNT_W          (CW)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .key_n_raw    (key_n_raw),
    .clr_count    (clr_count),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .press_count  (press_count)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // ---------------- reference model ----------------
  logic [1:0] m_dly;       // raw samples in flight to the "pressed" view
  logic [D:0] m_win;       // last D+1 pressed samples
  logic       m_level;
  logic       m_pp;
  logic       m_rp;
  logic       m_long;
  int         m_cnt;
  int         m_cyc;
  int         m_press_cyc;

  task automatic model_reset();
    m_dly       = 2'b11;
    m_win       = '0;
    m_level     = 1'b0;
    m_pp        = 1'b0;
    m_rp        = 1'b0;
    m_long      = 1'b0;
    m_cnt       = 0;
    m_cyc       = 0;
    m_press_cyc = 0;
  endtask

  task automatic model_edge();
    logic p;
    logic acc;
    p     = ~m_dly[1];
    m_dly = {m_dly[0], key_n_raw};
    m_cyc++;
    m_win = {m_win[D-1:0], p};
    acc   = 1'b0;
    m_pp  = 1'b0;
    m_rp  = 1'b0;
    if (!m_level && (m_win == {(D+1){1'b1}})) begin
      m_level     = 1'b1;
      m_pp        = 1'b1;
      acc         = 1'b1;
      m_press_cyc = m_cyc;
      m_win       = {(D+1){1'b1}};
    end else if (m_level && (m_win == {(D+1){1'b0}})) begin
      m_level = 1'b0;
      m_rp    = 1'b1;
      m_win   = {(D+1){1'b0}};
    end
    m_long = m_level && ((m_cyc - m_press_cyc) >= LG);
    if (clr_count) m_cnt = acc ? 1 : 0;
    else if (acc && (m_cnt < (1 << CW) - 1)) m_cnt++;
  endtask

  // ---------------- checking helpers ----------------
  function automatic logic [7:0] dut_vec();
    return {key_level, press_pulse, release_pulse, long_press, press_count};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One clock: model advances on the rising edge, DUT compared on the falling.
  task automatic tick();
    @(posedge clk_clk);
    model_edge();
    @(negedge clk_clk);
    chk($sformatf("model@cyc%0d", m_cyc), {24'd0, dut_vec()},
        {24'd0, m_level, m_pp, m_rp, m_long, 4'(m_cnt)});
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return key_level;
      1:       return press_pulse;
      2:       return release_pulse;
      default: return long_press;
    endcase
  endfunction

  // Ticks until the selected output is 1; k is the 0-based tick index or -1.
  task automatic wait_for(input int sel, input int max_ticks, output int k);
    k = -1;
    for (int i = 0; i < max_ticks; i++) begin
      tick();
      if (sig(sel)) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic press_release();
    key_n_raw = 1'b0;
    repeat (8) tick();
    key_n_raw = 1'b1;
    repeat (8) tick();
  endtask

  task automatic async_reset();
    #2;
    reset_reset_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       raw_n;
    logic       clr;
    logic [7:0] exp;   // {level, press, release, long, count[3:0]}
  } vec_t;

  vec_t vecs[30];

  initial begin
    automatic int k;
    automatic logic seen_rp;
    automatic logic lvl_drop;
    automatic int long_e;

    n_checks      = 0;
    n_errors      = 0;
    reset_reset_n = 1'b0;
    key_n_raw     = 1'b1;
    clr_count     = 1'b0;
    model_reset();

    // clean press, release, bounce, clear
    for (int i = 0; i < 30; i++) begin
      vecs[i].raw_n = 1'b1;
      vecs[i].clr   = 1'b0;
      vecs[i].exp   = 8'h01;
    end
    for (int i = 0; i < 10; i++) vecs[i].raw_n = 1'b0;
    for (int i = 0; i < 6; i++)  vecs[i].exp = 8'h00;
    vecs[6].exp = 8'b1100_0001;
    for (int i = 7; i < 16; i++) vecs[i].exp = 8'b1000_0001;
    vecs[16].exp = 8'b0010_0001;
    for (int i = 18; i < 21; i++) vecs[i].raw_n = 1'b0;
    vecs[28].clr = 1'b1;
    vecs[28].exp = 8'h00;
    vecs[29].exp = 8'h00;

    #3;
    chk("reset_state", {24'd0, dut_vec()}, 32'd0);
    release_reset();

    for (int i = 0; i < 30; i++) begin
      key_n_raw = vecs[i].raw_n;
      clr_count = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d", i), {24'd0, dut_vec()}, {24'd0, vecs[i].exp});
    end
    clr_count = 1'b0;

    // long hold: 40 cycles low, then release
    key_n_raw = 1'b0;
    wait_for(0, 20, k);
    chk("t3_press_latency", k, 6);
    wait_for(3, 30, k);
    chk("t3_long_after_level", k + 1, LG);
    repeat (40 - 7 - LG) tick();
    key_n_raw = 1'b1;
    wait_for(2, 20, k);
    chk("t3_release_latency", k, 6);
    chk("t3_level_low_at_release", key_level, 0);
    chk("t3_long_low_at_release", long_press, 0);
    tick();
    chk("t3_release_one_cycle", release_pulse, 0);

    // release glitch of two cycles while pressed
    key_n_raw = 1'b0;
    wait_for(0, 20, k);
    chk("t4_press_latency", k, 6);
    repeat (3) tick();
    key_n_raw = 1'b1;
    repeat (2) tick();
    key_n_raw = 1'b0;
    seen_rp  = 1'b0;
    lvl_drop = 1'b0;
    long_e   = -1;
    for (int e = 12; e < 32; e++) begin
      tick();
      seen_rp  = seen_rp | release_pulse;
      lvl_drop = lvl_drop | ~key_level;
      if (long_press && (long_e < 0)) long_e = e;
    end
    chk("t4_no_release_pulse", seen_rp, 0);
    chk("t4_level_held", lvl_drop, 0);
    chk("t4_long_edge", long_e, 6 + LG);
    key_n_raw = 1'b1;
    wait_for(2, 20, k);
    chk("t4_release_latency", k, 6);

    // counter: clear, saturate, coincident clear, clear
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("t5_clr_alone", press_count, 0);
    repeat (17) press_release();
    chk("t5_saturated", press_count, 15);
    key_n_raw = 1'b0;
    repeat (6) tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("t5_coinc_pulse", press_pulse, 1);
    chk("t5_coinc_count", press_count, 1);
    key_n_raw = 1'b1;
    repeat (8) tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("t5_clr_again", press_count, 0);
    press_release();

    // reset in PRESS_WAIT, key held through reset
    key_n_raw = 1'b0;
    repeat (4) tick();
    async_reset();
    chk("t6_async_clear_pw", {24'd0, dut_vec()}, 32'd0);
    release_reset();
    wait_for(1, 20, k);
    chk("t6_press_after_reset1", k, 6);
    wait_for(3, 30, k);
    chk("t6_long_before_reset", long_press, 1);
    async_reset();
    chk("t6_async_clear_pressed", {24'd0, dut_vec()}, 32'd0);
    release_reset();
    wait_for(1, 20, k);
    chk("t6_press_after_reset2", k, 6);
    key_n_raw = 1'b1;
    wait_for(2, 20, k);
    chk("t6_release_latency", k, 6);

    // randomised bursts checked cycle-by-cycle against the model
    for (int s = 0; s < 90; s++) begin
      automatic logic lvl = 1'($urandom_range(0, 1));
      automatic int   len = $urandom_range(1, 14);
      for (int j = 0; j < len; j++) begin
        key_n_raw = lvl;
        clr_count = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    clr_count = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
